// File: rtl/mac_pkg.sv
// Shared definitions for the MAC add sequencer: FSM states, arbitration modes
// and the carry-out recovery helper for the carry-less 32-bit adder.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        INC  = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    localparam logic [31:0] INC_ONE = 32'h0000_0001;

    // The adder exposes no bit-31 carry; rebuild it from the operand and sum MSBs.
    function automatic logic carry31(input logic a31, input logic b31, input logic s31);
        return (a31 & b31) | ((a31 ^ b31) & ~s31);
    endfunction

endpackage

// File: rtl/p405s_SM_ADD32INTCO.sv
// 32-bit adder without carry-in or carry-out; reports the carry out of each
// group ([9:0], then 2-bit groups up to [23:22]) on CP.
module p405s_SM_ADD32INTCO (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] s_o,
    output logic [7:0]  cp_o
);

    assign s_o = a_i + b_i;

    // Carry into bit j is recoverable as s[j]^a[j]^b[j].
    always_comb begin
        cp_o = '0;
        for (int k = 0; k < 8; k++) begin
            cp_o[k] = s_o[10 + 2 * k] ^ a_i[10 + 2 * k] ^ b_i[10 + 2 * k];
        end
    end

endmodule

// File: rtl/mac_add_sequencer.sv
// Arbitrates two requesters onto one shared 32-bit adder and sequences 64-bit
// adds as low, high and optional carry-increment passes.
module mac_add_sequencer
    import mac_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic        CB,
    input  logic        resetN,
    input  logic        r0_req,
    input  logic        r0_dw,
    input  logic [63:0] r0_a,
    input  logic [63:0] r0_b,
    output logic        r0_gnt,
    input  logic        r1_req,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    output logic        r1_gnt,
    output logic        res_valid,
    output logic        res_id,
    output logic [63:0] res_sum,
    output logic        res_cout,
    output logic [7:0]  res_cp,
    output logic        busy
);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [63:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic        id_q, id_d, dw_q, dw_d, clo_q, clo_d, chi_q, chi_d;
    logic [63:0] res_sum_q, res_sum_d;
    logic        res_id_q, res_id_d, res_cout_q, res_cout_d;
    logic [7:0]  res_cp_q, res_cp_d;

    logic [31:0] add_a, add_b, add_s;
    logic [7:0]  add_cp;
    logic        c_pass, r0_wins;

    always_comb begin
        add_a = a_q[31:0];
        add_b = b_q[31:0];
        case (state_q)
            HI: begin
                add_a = a_q[63:32];
                add_b = b_q[63:32];
            end
            INC: begin
                add_a = sum_q[63:32];
                add_b = INC_ONE;
            end
            default: ;
        endcase
    end

    p405s_SM_ADD32INTCO u_add (
        .a_i  (add_a),
        .b_i  (add_b),
        .s_o  (add_s),
        .cp_o (add_cp)
    );

    assign c_pass  = carry31(add_a[31], add_b[31], add_s[31]);
    assign r0_wins = r0_req && (!r1_req || (PRIO_MODE == PRIO_FIXED) || last_q);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        dw_d       = dw_q;
        sum_d      = sum_q;
        clo_d      = clo_q;
        chi_d      = chi_q;
        res_sum_d  = res_sum_q;
        res_id_d   = res_id_q;
        res_cout_d = res_cout_q;
        res_cp_d   = res_cp_q;
        r0_gnt     = 1'b0;
        r1_gnt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (r0_wins) begin
                    r0_gnt  = 1'b1;
                    a_d     = r0_a;
                    b_d     = r0_b;
                    id_d    = 1'b0;
                    dw_d    = r0_dw;
                    last_d  = 1'b0;
                    state_d = LO;
                end else if (r1_req) begin
                    r1_gnt  = 1'b1;
                    a_d     = {32'h0, r1_a};
                    b_d     = {32'h0, r1_b};
                    id_d    = 1'b1;
                    dw_d    = 1'b0;
                    last_d  = 1'b1;
                    state_d = LO;
                end
            end
            LO: begin
                sum_d[31:0] = add_s;
                clo_d       = c_pass;
                if (dw_q) begin
                    state_d = HI;
                end else begin
                    res_sum_d  = {32'h0, add_s};
                    res_cout_d = c_pass;
                    res_cp_d   = add_cp;
                    res_id_d   = id_q;
                    state_d    = DONE;
                end
            end
            HI: begin
                sum_d[63:32] = add_s;
                chi_d        = c_pass;
                if (clo_q) begin
                    state_d = INC;
                end else begin
                    res_sum_d  = {add_s, sum_q[31:0]};
                    res_cout_d = c_pass;
                    res_cp_d   = add_cp;
                    res_id_d   = id_q;
                    state_d    = DONE;
                end
            end
            INC: begin
                // The high half overflows on the increment only when it was all ones.
                sum_d[63:32] = add_s;
                res_sum_d    = {add_s, sum_q[31:0]};
                res_cout_d   = chi_q | (sum_q[63:32] == 32'hFFFF_FFFF);
                res_cp_d     = add_cp;
                res_id_d     = id_q;
                state_d      = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CB) begin
        if (!resetN) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            res_sum_q  <= '0;
            res_id_q   <= 1'b0;
            res_cout_q <= 1'b0;
            res_cp_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            res_sum_q  <= res_sum_d;
            res_id_q   <= res_id_d;
            res_cout_q <= res_cout_d;
            res_cp_q   <= res_cp_d;
        end
    end

    always_ff @(posedge CB) begin
        a_q   <= a_d;
        b_q   <= b_d;
        id_q  <= id_d;
        dw_q  <= dw_d;
        sum_q <= sum_d;
        clo_q <= clo_d;
        chi_q <= chi_d;
    end

    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign res_sum   = res_sum_q;
    assign res_id    = res_id_q;
    assign res_cout  = res_cout_q;
    assign res_cp    = res_cp_q;

endmodule
